// File: rtl/id_stage_pipe_pkg.sv
// id_stage_pipe_pkg: constants shared by the decode stage and its decoder.
// Holds the RV32I opcode / funct3 / funct7 values, the ALU operation codes
// consumed by execute, and the control bundle the decoder returns.
package id_stage_pipe_pkg;

  localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
  localparam logic [6:0] OPC_ITYPE  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_LW_SW   = 3'b010;
  localparam logic [2:0] F3_SRA     = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;
  localparam logic [2:0] F3_BEQ     = 3'b000;
  localparam logic [2:0] F3_BNE     = 3'b001;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [3:0] ADD_ALU = 4'd0;
  localparam logic [3:0] SUB_ALU = 4'd1;
  localparam logic [3:0] AND_ALU = 4'd2;
  localparam logic [3:0] OR_ALU  = 4'd3;
  localparam logic [3:0] SLL_ALU = 4'd4;
  localparam logic [3:0] SRA_ALU = 4'd5;
  localparam logic [3:0] LW_ALU  = 4'd6;
  localparam logic [3:0] SW_ALU  = 4'd7;

  typedef struct packed {
    logic [3:0] alu_op;
    logic       used_rs1;
    logic       used_rs2;
    logic       rd_we;
    logic       is_load;
    logic       is_store;
    logic       is_branch;
    logic       illegal;
  } dec_ctl_t;

endpackage

// File: rtl/id_stage_pipe_id_decoder.sv
// id_decoder: purely combinational RV32I decode for the ID stage.
//   inst       in   32-bit instruction word
//   ctl        out  alu_op, source-use flags, rd_we, load/store/branch, illegal
//   imm        out  ADDI I-immediate or branch B-immediate, else 0
//   mem_offset out  LW I-offset / SW S-offset, else 0
// Build option: ID_BRANCH_EN enables BEQ/BNE; without it opcode 1100011 is illegal.
module id_decoder
  import id_stage_pipe_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     inst,
  output dec_ctl_t        ctl,
  output logic [XLEN-1:0] imm,
  output logic [XLEN-1:0] mem_offset
);

  logic [6:0] opc, f7;
  logic [2:0] f3;
  logic [XLEN-1:0] imm_i, imm_s;

  assign opc   = inst[6:0];
  assign f3    = inst[14:12];
  assign f7    = inst[31:25];
  assign imm_i = {{(XLEN-12){inst[31]}}, inst[31:20]};
  assign imm_s = {{(XLEN-12){inst[31]}}, inst[31:25], inst[11:7]};

  always_comb begin
    ctl        = '0;
    imm        = '0;
    mem_offset = '0;
    case (opc)
      OPC_RTYPE: begin
        ctl.used_rs1 = 1'b1;
        ctl.used_rs2 = 1'b1;
        ctl.rd_we    = 1'b1;
        case ({f7, f3})
          {F7_BASE, F3_ADD_SUB}: ctl.alu_op = ADD_ALU;
          {F7_ALT,  F3_ADD_SUB}: ctl.alu_op = SUB_ALU;
          {F7_BASE, F3_AND}:     ctl.alu_op = AND_ALU;
          {F7_BASE, F3_OR}:      ctl.alu_op = OR_ALU;
          {F7_BASE, F3_SLL}:     ctl.alu_op = SLL_ALU;
          {F7_ALT,  F3_SRA}:     ctl.alu_op = SRA_ALU;
          default:               ctl.illegal = 1'b1;
        endcase
      end
      OPC_ITYPE: begin
        ctl.used_rs1 = 1'b1;
        ctl.rd_we    = 1'b1;
        ctl.alu_op   = ADD_ALU;
        imm          = imm_i;
        ctl.illegal  = (f3 != F3_ADD_SUB);
      end
      OPC_LOAD: begin
        ctl.used_rs1 = 1'b1;
        ctl.rd_we    = 1'b1;
        ctl.is_load  = 1'b1;
        ctl.alu_op   = LW_ALU;
        mem_offset   = imm_i;
        ctl.illegal  = (f3 != F3_LW_SW);
      end
      OPC_STORE: begin
        ctl.used_rs1 = 1'b1;
        ctl.used_rs2 = 1'b1;
        ctl.is_store = 1'b1;
        ctl.alu_op   = SW_ALU;
        mem_offset   = imm_s;
        ctl.illegal  = (f3 != F3_LW_SW);
      end
`ifdef ID_BRANCH_EN
      OPC_BRANCH: begin
        ctl.used_rs1  = 1'b1;
        ctl.used_rs2  = 1'b1;
        ctl.is_branch = 1'b1;
        imm = {{(XLEN-12){inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
        ctl.illegal = (f3 != F3_BEQ) && (f3 != F3_BNE);
      end
`endif
      default: ctl.illegal = 1'b1;
    endcase
    // An illegal word reads nothing and writes nothing.
    if (ctl.illegal) begin
      ctl         = '0;
      ctl.illegal = 1'b1;
      imm         = '0;
      mem_offset  = '0;
    end
    if (inst[11:7] == 5'd0) ctl.rd_we = 1'b0;
  end

endmodule

// File: rtl/id_stage_pipe.sv
// id_stage_pipe: registered RV32I decode stage with the ID/EX register.
//   clk, reset               clock, synchronous active-high reset
//   in_valid/in_ready        fetch handshake (in_ready combinational)
//   in_pc, in_inst           instruction and its PC
//   r1_addr/r2_addr          register-file read addresses (comb, 0 if unused)
//   r1_data/r2_data          register-file read data
//   out_valid/out_ready      execute handshake
//   op_1, op_2, mem_offset, store_data, rd_addr, rd_we, alu_op, pc_out  ID/EX fields
//   br, branch_addr          taken-branch pulse and target to fetch
//   illegal                  pulse when an undecodable word is accepted
// Build option: ID_BRANCH_EN enables BEQ/BNE resolution and the SQUASH state.
module id_stage_pipe
  import id_stage_pipe_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int RA_W = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [31:0]     in_inst,
  output logic [RA_W-1:0] r1_addr,
  output logic [RA_W-1:0] r2_addr,
  input  logic [XLEN-1:0] r1_data,
  input  logic [XLEN-1:0] r2_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] op_1,
  output logic [XLEN-1:0] op_2,
  output logic [XLEN-1:0] mem_offset,
  output logic [XLEN-1:0] store_data,
  output logic [RA_W-1:0] rd_addr,
  output logic            rd_we,
  output logic [3:0]      alu_op,
  output logic [XLEN-1:0] pc_out,
  output logic            br,
  output logic [XLEN-1:0] branch_addr,
  output logic            illegal
);

`ifdef ID_BRANCH_EN
  typedef enum logic [1:0] {RUN, LU_BUBBLE, SQUASH} state_t;
`else
  typedef enum logic [1:0] {RUN, LU_BUBBLE} state_t;
`endif

  state_t          state, state_nxt;
  dec_ctl_t        ctl;
  logic [XLEN-1:0] imm, moff;
  logic [RA_W-1:0] rs1, rs2, rd, ld_rd;
  logic            ld_pending, load_en, hazard, in_xfer, in_squash, taken, br_take, live;

  id_decoder #(.XLEN(XLEN)) u_dec (.inst(in_inst), .ctl(ctl), .imm(imm), .mem_offset(moff));

  assign rs1     = RA_W'(in_inst[19:15]);
  assign rs2     = RA_W'(in_inst[24:20]);
  assign rd      = RA_W'(in_inst[11:7]);
  assign r1_addr = ctl.used_rs1 ? rs1 : '0;
  assign r2_addr = ctl.used_rs2 ? rs2 : '0;

  assign load_en = !out_valid || out_ready;
  // ld_pending is only ever set in RUN, so LU_BUBBLE sees it cleared.
  assign hazard  = (state == RUN) && ld_pending && in_valid &&
                   ((ctl.used_rs1 && rs1 == ld_rd) || (ctl.used_rs2 && rs2 == ld_rd));

`ifdef ID_BRANCH_EN
  assign in_squash = (state == SQUASH);
  assign taken     = ctl.is_branch && (in_inst[12] ? (r1_data != r2_data) : (r1_data == r2_data));
`else
  assign in_squash = 1'b0;
  assign taken     = 1'b0;
`endif

  // The register is always empty in SQUASH (the branch loaded a bubble).
  assign in_ready = in_squash || (load_en && !hazard);
  assign in_xfer  = in_valid && in_ready;
  assign br_take  = in_xfer && !in_squash && taken;
  assign live     = in_xfer && !in_squash && !ctl.illegal && !ctl.is_branch;

  always_comb begin
    state_nxt = state;
    case (state)
      RUN, LU_BUBBLE: begin
        if (hazard && load_en) state_nxt = LU_BUBBLE;
        else if (in_xfer)      state_nxt = RUN;
`ifdef ID_BRANCH_EN
        if (br_take) state_nxt = SQUASH;
      end
      SQUASH: begin
        if (in_xfer) state_nxt = RUN;
`endif
      end
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= RUN;
      ld_pending <= 1'b0;
      ld_rd      <= '0;
      out_valid  <= 1'b0;
      op_1       <= '0;
      op_2       <= '0;
      mem_offset <= '0;
      store_data <= '0;
      rd_addr    <= '0;
      rd_we      <= 1'b0;
      alu_op     <= '0;
      pc_out     <= '0;
      illegal    <= 1'b0;
    end else begin
      state   <= state_nxt;
      illegal <= in_xfer && !in_squash && ctl.illegal;
      if (load_en) begin
        // Bubbles, branches, squashed and illegal words load an all-zero slot.
        out_valid  <= live;
        ld_pending <= live && ctl.is_load && ctl.rd_we;
        ld_rd      <= live ? rd : '0;
        op_1       <= (live && ctl.used_rs1) ? r1_data : '0;
        op_2       <= !live || ctl.is_store ? '0 : (ctl.used_rs2 ? r2_data : imm);
        mem_offset <= live ? moff : '0;
        store_data <= (live && ctl.is_store) ? r2_data : '0;
        rd_addr    <= live ? rd : '0;
        rd_we      <= live && ctl.rd_we;
        alu_op     <= live ? ctl.alu_op : '0;
        pc_out     <= live ? in_pc : '0;
      end
    end
  end

`ifdef ID_BRANCH_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      br          <= 1'b0;
      branch_addr <= '0;
    end else begin
      br          <= br_take;
      branch_addr <= br_take ? in_pc + imm : '0;
    end
  end
`else
  assign br          = 1'b0;
  assign branch_addr = '0;
`endif

endmodule

// File: tb/tb_id_stage_pipe.sv
module tb_id_stage_pipe;

  logic        clk = 1'b0, reset = 1'b1;
  logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1;
  logic [31:0] in_pc = '0, in_inst = '0, r1_data, r2_data;
  logic [4:0]  r1_addr, r2_addr, rd_addr;
  logic [31:0] op_1, op_2, mem_offset, store_data, pc_out, branch_addr;
  logic        rd_we, br, illegal;
  logic [3:0]  alu_op;
  logic [31:0] rf [32];
  int n_vec = 0, n_err = 0;

  localparam logic [31:0] I_ADD3  = 32'h002081B3; // add  x3,x1,x2
  localparam logic [31:0] I_ADDI4 = 32'hFFF00213; // addi x4,x0,-1
  localparam logic [31:0] I_LW5   = 32'h0080A283; // lw   x5,8(x1)
  localparam logic [31:0] I_ADD6  = 32'h00228333; // add  x6,x5,x2
  localparam logic [31:0] I_SUB7  = 32'h402083B3; // sub  x7,x1,x2
  localparam logic [31:0] I_SW    = 32'h0020A623; // sw   x2,12(x1)
  localparam logic [31:0] I_ADD0  = 32'h00208033; // add  x0,x1,x2
  localparam logic [31:0] I_BEQ   = 32'h00108863; // beq  x1,x1,+16
  localparam logic [31:0] I_MUL   = 32'h020081B3; // funct7 0000001 on funct3 000

  always #5 clk = ~clk;

  assign r1_data = rf[r1_addr];
  assign r2_data = rf[r2_addr];

  id_stage_pipe dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
    .in_inst(in_inst), .r1_addr(r1_addr), .r2_addr(r2_addr), .r1_data(r1_data),
    .r2_data(r2_data), .out_valid(out_valid), .out_ready(out_ready), .op_1(op_1),
    .op_2(op_2), .mem_offset(mem_offset), .store_data(store_data), .rd_addr(rd_addr),
    .rd_we(rd_we), .alu_op(alu_op), .pc_out(pc_out), .br(br), .branch_addr(branch_addr),
    .illegal(illegal)
  );

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] inst);
    in_valid = v; in_pc = pc; in_inst = inst; #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; drive(1'b0, 32'h0, 32'h0);
    tick(); tick(); reset = 1'b0; #1;
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset out_valid got %b want 0", out_valid); end
    n_vec++; if ({br, illegal, rd_we} !== 3'b000) begin n_err++; $display("FAIL reset pulses got %b want 000", {br, illegal, rd_we}); end
    n_vec++; if ({op_1, op_2, pc_out} !== 96'h0) begin n_err++; $display("FAIL reset data got %h want 0", {op_1, op_2, pc_out}); end
    n_vec++; if ({alu_op, rd_addr} !== 9'h0) begin n_err++; $display("FAIL reset alu/rd got %h want 0", {alu_op, rd_addr}); end
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_add();
    drive(1'b1, 32'h10, I_ADD3);
    n_vec++; if ({r1_addr, r2_addr} !== {5'd1, 5'd2}) begin n_err++; $display("FAIL add raddr got %h want 022", {r1_addr, r2_addr}); end
    tick(); drive(1'b0, 32'h0, 32'h0);
    n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL add out_valid got %b want 1", out_valid); end
    n_vec++; if ({op_1, op_2} !== {32'd5, 32'd7}) begin n_err++; $display("FAIL add ops got %h want 5/7", {op_1, op_2}); end
    n_vec++; if ({alu_op, rd_addr, rd_we} !== {4'd0, 5'd3, 1'b1}) begin n_err++; $display("FAIL add ctl got %h want alu0 rd3 we1", {alu_op, rd_addr, rd_we}); end
    n_vec++; if (pc_out !== 32'h10) begin n_err++; $display("FAIL add pc_out got %h want 10", pc_out); end
  endtask

  task automatic test_addi_backpressure();
    drive(1'b1, 32'h14, I_ADDI4);
    n_vec++; if ({r1_addr, r2_addr} !== 10'h0) begin n_err++; $display("FAIL addi raddr got %h want 0", {r1_addr, r2_addr}); end
    tick(); out_ready = 1'b0; drive(1'b1, 32'h18, I_ADD3);
    n_vec++; if ({op_1, op_2} !== {32'd0, 32'hFFFFFFFF}) begin n_err++; $display("FAIL addi ops got %h want 0/ffffffff", {op_1, op_2}); end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL stall in_ready cyc%0d got %b want 0", i, in_ready); end
      n_vec++; if ({out_valid, op_2, rd_addr, pc_out} !== {1'b1, 32'hFFFFFFFF, 5'd4, 32'h14}) begin
        n_err++; $display("FAIL stall hold cyc%0d got %h want held addi", i, {out_valid, op_2, rd_addr, pc_out}); end
    end
    out_ready = 1'b1; drive(1'b0, 32'h0, 32'h0); tick();
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL stall drain got %b want 0", out_valid); end
  endtask

  task automatic test_load_use();
    drive(1'b1, 32'h20, I_LW5); tick(); drive(1'b1, 32'h24, I_ADD6);
    n_vec++; if ({out_valid, alu_op, rd_addr, rd_we} !== {1'b1, 4'd6, 5'd5, 1'b1}) begin n_err++; $display("FAIL lw ctl got %h want v1 alu6 rd5 we1", {out_valid, alu_op, rd_addr, rd_we}); end
    n_vec++; if ({mem_offset, op_1, op_2} !== {32'd8, 32'd5, 32'd0}) begin n_err++; $display("FAIL lw data got %h want 8/5/0", {mem_offset, op_1, op_2}); end
    n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL lu hazard in_ready got %b want 0", in_ready); end
    tick();
    n_vec++; if ({out_valid, in_ready} !== 2'b01) begin n_err++; $display("FAIL lu bubble got v/rdy %b want 01", {out_valid, in_ready}); end
    tick(); drive(1'b0, 32'h0, 32'h0);
    n_vec++; if ({out_valid, rd_addr, op_1, op_2, pc_out} !== {1'b1, 5'd6, 32'd100, 32'd7, 32'h24}) begin
      n_err++; $display("FAIL lu add got %h want v1 rd6 100/7 pc24", {out_valid, rd_addr, op_1, op_2, pc_out}); end
    tick();
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 32'h30, I_SUB7); tick(); drive(1'b1, 32'h34, I_SW);
    n_vec++; if ({out_valid, alu_op, rd_addr, op_1, op_2} !== {1'b1, 4'd1, 5'd7, 32'd5, 32'd7}) begin
      n_err++; $display("FAIL b2b sub got %h want v1 alu1 rd7 5/7", {out_valid, alu_op, rd_addr, op_1, op_2}); end
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL b2b in_ready got %b want 1", in_ready); end
    tick(); drive(1'b1, 32'h38, I_ADD0);
    n_vec++; if ({out_valid, alu_op, rd_we, pc_out} !== {1'b1, 4'd7, 1'b0, 32'h34}) begin n_err++; $display("FAIL b2b sw ctl got %h want v1 alu7 we0 pc34", {out_valid, alu_op, rd_we, pc_out}); end
    n_vec++; if ({op_2, store_data, mem_offset} !== {32'd0, 32'd7, 32'd12}) begin n_err++; $display("FAIL b2b sw data got %h want 0/7/12", {op_2, store_data, mem_offset}); end
    tick(); drive(1'b0, 32'h0, 32'h0);
    n_vec++; if ({out_valid, rd_we, alu_op} !== {1'b1, 1'b0, 4'd0}) begin n_err++; $display("FAIL x0 write got %h want v1 we0 alu0", {out_valid, rd_we, alu_op}); end
    tick();
  endtask

  task automatic test_branch();
    drive(1'b1, 32'h100, I_BEQ);
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL beq in_ready got %b want 1", in_ready); end
    tick(); drive(1'b1, 32'h104, I_ADD3);
`ifdef ID_BRANCH_EN
    n_vec++; if ({br, branch_addr, illegal} !== {1'b1, 32'h110, 1'b0}) begin n_err++; $display("FAIL beq br got %h want br1 110 ill0", {br, branch_addr, illegal}); end
    n_vec++; if ({out_valid, in_ready} !== 2'b01) begin n_err++; $display("FAIL beq slot got v/rdy %b want 01", {out_valid, in_ready}); end
    tick(); drive(1'b1, 32'h108, I_SUB7);
    n_vec++; if ({out_valid, br} !== 2'b00) begin n_err++; $display("FAIL squash got v/br %b want 00", {out_valid, br}); end
`else
    n_vec++; if ({br, illegal, out_valid} !== 3'b010) begin n_err++; $display("FAIL beq off got br/ill/v %b want 010", {br, illegal, out_valid}); end
    tick(); drive(1'b1, 32'h108, I_SUB7);
    n_vec++; if ({out_valid, alu_op, pc_out} !== {1'b1, 4'd0, 32'h104}) begin n_err++; $display("FAIL beq off next got %h want v1 alu0 pc104", {out_valid, alu_op, pc_out}); end
`endif
    tick(); drive(1'b0, 32'h0, 32'h0);
    n_vec++; if ({out_valid, alu_op, pc_out, br} !== {1'b1, 4'd1, 32'h108, 1'b0}) begin n_err++; $display("FAIL post-branch got %h want v1 alu1 pc108 br0", {out_valid, alu_op, pc_out, br}); end
    tick();
  endtask

  task automatic test_illegal();
    drive(1'b1, 32'h200, 32'hFFFFFFFF); tick(); drive(1'b0, 32'h0, 32'h0);
    n_vec++; if ({illegal, out_valid} !== 2'b10) begin n_err++; $display("FAIL ill ffff got ill/v %b want 10", {illegal, out_valid}); end
    tick();
    n_vec++; if (illegal !== 1'b0) begin n_err++; $display("FAIL ill pulse width got %b want 0", illegal); end
    drive(1'b1, 32'h204, I_MUL); tick(); drive(1'b0, 32'h0, 32'h0);
    n_vec++; if ({illegal, out_valid} !== 2'b10) begin n_err++; $display("FAIL ill funct7 got ill/v %b want 10", {illegal, out_valid}); end
    tick();
  endtask

  task automatic test_reset_mid_stall();
    // Reset during LU_BUBBLE.
    drive(1'b1, 32'h300, I_LW5); tick(); drive(1'b1, 32'h304, I_ADD6); tick();
    drive(1'b0, 32'h0, 32'h0); reset = 1'b1; tick(); reset = 1'b0; #1;
    n_vec++; if ({out_valid, rd_we, op_1, pc_out, alu_op} !== 70'h0) begin n_err++; $display("FAIL rst bubble outs got %h want 0", {out_valid, rd_we, op_1, pc_out, alu_op}); end
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst bubble in_ready got %b want 1", in_ready); end
    // Reset while a load is held under backpressure with a dependent waiting.
    drive(1'b1, 32'h310, I_LW5); tick(); out_ready = 1'b0; drive(1'b1, 32'h314, I_ADD6);
    n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL rst stall pre in_ready got %b want 0", in_ready); end
    reset = 1'b1; tick(); reset = 1'b0; out_ready = 1'b1; #1;
    n_vec++; if ({out_valid, in_ready} !== 2'b01) begin n_err++; $display("FAIL rst stall post got v/rdy %b want 01", {out_valid, in_ready}); end
    tick(); drive(1'b0, 32'h0, 32'h0);
    n_vec++; if ({out_valid, rd_addr} !== {1'b1, 5'd6}) begin n_err++; $display("FAIL rst stall issue got %h want v1 rd6", {out_valid, rd_addr}); end
    tick();
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 32'd0;
    rf[1] = 32'd5; rf[2] = 32'd7; rf[5] = 32'd100;
    test_reset();
    test_add();
    test_addi_backpressure();
    test_load_use();
    test_back_to_back();
    test_branch();
    test_illegal();
    test_reset_mid_stall();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
